// File: rtl/ppufb_pkg.sv
// Shared types and frame geometry for the PPU framebuffer writer.
// FBWIDTH/FBHEIGHT/FBSTRIDE are also used by the scan-out side.
`ifndef FBWIDTH
`define FBWIDTH 256
`endif
`ifndef FBHEIGHT
`define FBHEIGHT 240
`endif
`ifndef FBSTRIDE
`define FBSTRIDE 32'h0004_0000
`endif

package ppufb_pkg;

  localparam logic [8:0]  FB_W9     = 9'(`FBWIDTH);
  localparam logic [8:0]  FB_H9     = 9'(`FBHEIGHT);
  localparam logic [31:0] FB_STRIDE = `FBSTRIDE;

  typedef struct packed {
    logic        eof;
    logic [7:0]  y;
    logic [7:0]  x;
    logic [23:0] pix;
  } fbent_t;

  // Byte offset of a pixel inside one buffer: one 32-bit word per pixel, 256 words per row.
  function automatic logic [31:0] fb_offset(input logic [7:0] y, input logic [7:0] x);
    return {14'b0, y, x, 2'b00};
  endfunction

endpackage

// File: rtl/pxfifo.sv
// Synchronous FIFO with combinational head read; push into a full FIFO is
// accepted when a pop happens on the same edge.
module pxfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/ppufb.sv
// PPU framebuffer writer: buffers visible pixels and writes one word per pixel
// over req/ack. Define FB_DOUBLE_EN for alternating front/back buffers.
import ppufb_pkg::*;

module ppufb #(
  parameter logic [31:0] FBBASE    = 32'h0010_0000,
  parameter int          FIFODEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  outx,
  input  logic [8:0]  outy,
  input  logic        pxvalid,
  input  logic [23:0] pix,
  output logic [31:0] fbaddr,
  output logic [31:0] fbwdata,
  output logic        fbreq,
  input  logic        fback,
  output logic        front,
  output logic        framedone,
  output logic        ovf
);

  fbent_t ent_in, head;
  logic   armed, back, origin, acc, pop, full, empty;

  // The (0,0) pixel both arms the writer and is accepted itself.
  assign origin = pxvalid && (outx == '0) && (outy == '0);
  assign acc    = pxvalid && (outx < FB_W9) && (outy < FB_H9) && (armed || origin);
  assign fbreq  = !empty;
  assign pop    = fbreq && fback;

  always_comb begin
    ent_in     = '0;
    ent_in.eof = (outx == FB_W9 - 9'd1) && (outy == FB_H9 - 9'd1);
    ent_in.y   = outy[7:0];
    ent_in.x   = outx[7:0];
    ent_in.pix = pix;
  end

  pxfifo #(.W($bits(fbent_t)), .DEPTH(FIFODEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (acc),
    .pop   (pop),
    .din   (ent_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 1'b0;
      ovf       <= 1'b0;
      framedone <= 1'b0;
    end else begin
      armed     <= armed | origin;
      framedone <= pop && head.eof;
      if (acc && full && !pop) ovf <= 1'b1;
    end
  end

`ifdef FB_DOUBLE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      back  <= 1'b0;
      front <= 1'b1;
    end else if (pop && head.eof) begin
      front <= back;
      back  <= !back;
    end
  end
`else
  assign back  = 1'b0;
  assign front = 1'b0;
`endif

  // Address follows the buffer selected when the word is presented, not when it was captured.
  assign fbaddr  = fbreq ? (FBBASE + (back ? FB_STRIDE : 32'h0) + fb_offset(head.y, head.x)) : 32'h0;
  assign fbwdata = fbreq ? {8'h00, head.pix} : 32'h0;

endmodule

// File: tb/tb_ppufb.sv
// Bench for ppufb: queue-based reference model compared every cycle, plus
// hand-computed literal checks on addresses, counts and flags.
module tb_ppufb;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h0010_0000;
  localparam logic [31:0] STRIDE = 32'h0004_0000;
`ifdef FB_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  outx = '0, outy = '0;
  logic        pxvalid = 1'b0;
  logic [23:0] pix = '0;
  logic        fback = 1'b0;
  logic [31:0] fbaddr, fbwdata;
  logic        fbreq, front, framedone, ovf;

  always #5 clk = ~clk;

  ppufb #(.FBBASE(BASE), .FIFODEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .outx(outx), .outy(outy), .pxvalid(pxvalid),
    .pix(pix), .fbaddr(fbaddr), .fbwdata(fbwdata), .fbreq(fbreq), .fback(fback),
    .front(front), .framedone(framedone), .ovf(ovf)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pf(input int x, input int y);
    logic [7:0] a, b, s;
    a = x[7:0];
    b = y[7:0];
    s = a + b;
    return {a ^ 8'h3c, b, s};
  endfunction

  // Reference model: pending pixels in a queue, buffer state as plain bits.
  typedef struct {
    int          x;
    int          y;
    logic [23:0] p;
  } pxr_t;

  pxr_t mq[$];
  pxr_t mh;
  bit   m_armed, m_ovf, m_fd, m_back, m_front, m_pop;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_armed = 0; m_ovf = 0; m_fd = 0; m_back = 0; m_front = DBL;
    end else begin
      m_pop = (mq.size() != 0) && fback;
      m_fd  = 0;
      if (m_pop) begin
        mh = mq.pop_front();
        if (mh.x == 255 && mh.y == 239) begin
          m_fd = 1;
          if (DBL) begin
            m_front = m_back;
            m_back  = !m_back;
          end
        end
      end
      if (pxvalid && outx == 0 && outy == 0) m_armed = 1;
      if (pxvalid && outx < 256 && outy < 240 && m_armed) begin
        if (mq.size() < DEPTH) mq.push_back('{int'(outx), int'(outy), pix});
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle compare and DUT transfer bookkeeping, away from the active edge.
  bit          chk_en = 0;
  int          dwr = 0, dfd = 0, grab_id = 0, grab_seen = 0;
  logic [31:0] dfirst = '0, dfirst_d = '0, dlast = '0, ea, ed;
  bit          er;

  always @(negedge clk) begin
    if (chk_en) begin
      er = (mq.size() != 0);
      ea = '0;
      ed = '0;
      if (er) begin
        ea = BASE + (m_back ? STRIDE : 32'h0) + {14'b0, 8'(mq[0].y), 8'(mq[0].x), 2'b00};
        ed = {8'h00, mq[0].p};
      end
      chk("outputs", {4'h0, fbreq, fbaddr, fbwdata, framedone, ovf, front},
                     {4'h0, er, ea, ed, m_fd, m_ovf, m_front});
      if (fbreq && fback && !reset) begin
        dwr++;
        dlast = fbaddr;
        if (grab_seen != grab_id) begin
          grab_seen = grab_id;
          dfirst    = fbaddr;
          dfirst_d  = fbwdata;
        end
      end
      if (framedone) dfd++;
    end
  end

  task automatic cyc(input bit v, input int x, input int y, input bit ack);
    pxvalid = v;
    outx    = 9'(x);
    outy    = 9'(y);
    pix     = pf(x, y);
    fback   = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && mq.size() != 0; i++) cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("drain_bound", 72'(mq.size()), 72'd0);
  endtask

  int n0;

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    repeat (2) cyc(0, 0, 0, 0);
    chk("rst_fbreq", 72'(fbreq), 72'd0);
    chk("rst_fbaddr", 72'(fbaddr), 72'd0);
    chk("rst_fbwdata", 72'(fbwdata), 72'd0);
    chk("rst_ovf_fd", 72'({ovf, framedone}), 72'd0);
    chk("rst_front", 72'(front), 72'(DBL));
    reset = 0;

    // Mid-frame start and trailer pixels must not produce writes.
    for (int x = 10; x < 20; x++) cyc(1, x, 100, 1);
    cyc(1, 256, 0, 1);
    cyc(1, 256, 239, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("arm_nowrite", 72'(dwr), 72'd0);

    // Full frame, one pixel per cycle including the x=256 trailer.
    grab_id++;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 257; x++) cyc(1, x, y, 1);
    drain();
    chk("f1_writes", 72'(dwr), 72'd61440);
    chk("f1_first_addr", 72'(dfirst), 72'h0010_0000);
    chk("f1_first_data", 72'(dfirst_d), 72'h003c_0000);
    chk("f1_last_addr", 72'(dlast), 72'h0013_BFFC);   // base + (239<<10) + (255<<2)
    chk("f1_framedone", 72'(dfd), 72'd1);
    chk("f1_front", 72'(front), 72'd0);

    // Sparse second frame lands in the other buffer when double buffered.
    grab_id++;
    cyc(1, 0, 0, 1);
    cyc(1, 5, 3, 1);
    cyc(1, 255, 239, 1);
    drain();
    chk("f2_first_addr", 72'(dfirst), DBL ? 72'h0014_0000 : 72'h0010_0000);
    chk("f2_front", 72'(front), 72'(DBL));
    chk("f2_framedone", 72'(dfd), 72'd2);

    // Fill the FIFO, then push on the same edge as an ack.
    for (int x = 0; x < 16; x++) cyc(1, x, 0, 0);
    cyc(1, 16, 0, 1);
    chk("simul_noovf", 72'(ovf), 72'd0);

    // Stall for 20 cycles with a pixel every cycle: all are dropped.
    for (int x = 17; x < 37; x++) cyc(1, x, 0, 0);
    chk("bp_ovf", 72'(ovf), 72'd1);
    n0 = dwr;
    drain();
    chk("bp_held", 72'(dwr - n0), 72'd16);
    cyc(1, 255, 239, 1);
    drain();
    chk("f3_framedone", 72'(dfd), 72'd3);
    chk("ovf_sticky", 72'(ovf), 72'd1);

    // Reset while a write is outstanding.
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    chk("mid_fbreq", 72'(fbreq), 72'd1);
    reset = 1;
    cyc(0, 0, 0, 0);
    reset = 0;
    chk("rst2_fbreq", 72'(fbreq), 72'd0);
    chk("rst2_front", 72'(front), 72'(DBL));
    chk("rst2_ovf", 72'(ovf), 72'd0);
    n0 = dwr;
    cyc(1, 3, 0, 1);
    cyc(1, 4, 0, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("rst2_disarmed", 72'(dwr - n0), 72'd0);
    grab_id++;
    cyc(1, 0, 0, 1);
    drain();
    chk("rst2_resume_addr", 72'(dfirst), 72'h0010_0000);
    chk("rst2_resume_cnt", 72'(dwr - n0), 72'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
